// File: rtl/cov_toggle_monitor_if.sv
// cov_toggle_monitor_if: sampling, read-port and summary-scan signals of the toggle monitor
// master drives samples and requests; slave (the monitor) returns responses and totals
interface cov_toggle_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int AW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(NUM_CH * (WIDTH + 1) + 1);
  logic cov_en;
  logic sample_valid;
  logic [NUM_CH*WIDTH-1:0] sample_data;
  logic clear_req;
  logic rd_valid;
  logic rd_ready;
  logic [AW-1:0] rd_addr;
  logic rsp_valid;
  logic rsp_err;
  logic [CNT_W-1:0] rsp_count;
  logic [WIDTH-1:0] rsp_rise;
  logic [WIDTH-1:0] rsp_fall;
  logic sum_req;
  logic sum_busy;
  logic sum_done;
  logic [TW-1:0] covered_total;
  logic [TW-1:0] bins_total;
  modport master (
    output cov_en, sample_valid, sample_data, clear_req, rd_valid, rd_addr, sum_req,
    input rd_ready, rsp_valid, rsp_err, rsp_count, rsp_rise, rsp_fall, sum_busy, sum_done,
    covered_total, bins_total
  );
  modport slave (
    input cov_en, sample_valid, sample_data, clear_req, rd_valid, rd_addr, sum_req,
    output rd_ready, rsp_valid, rsp_err, rsp_count, rsp_rise, rsp_fall, sum_busy, sum_done,
    covered_total, bins_total
  );
endinterface

// File: rtl/cov_toggle_monitor.sv
// cov_toggle_monitor: per-channel toggle coverage (change counters, rise/fall masks), read port and summary scan
// ports: clock, reset (synchronous, active-high); bus (slave modport) carries sampling, read and summary signals
module cov_toggle_monitor #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int THRESH = 1
) (
  input logic clock,
  input logic reset,
  cov_toggle_monitor_if.slave bus
);
  localparam int AW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(NUM_CH * (WIDTH + 1) + 1);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [WIDTH-1:0] rise_q [NUM_CH];
  logic [WIDTH-1:0] fall_q [NUM_CH];
  logic [WIDTH-1:0] last_q [NUM_CH];
  logic primed_q;
  logic [AW-1:0] idx_q;
  logic [TW-1:0] acc_q, acc_d, covered_q;
  logic done_q, rsp_valid_q, rsp_err_q;
  logic [CNT_W-1:0] rsp_count_q;
  logic [WIDTH-1:0] rsp_rise_q, rsp_fall_q;
  logic rd_acc, in_rng, clr, smp;
  assign clr = reset || bus.clear_req;
  assign smp = bus.cov_en && bus.sample_valid;
  assign rd_acc = bus.rd_valid && state_q == IDLE;
  assign in_rng = int'(bus.rd_addr) < NUM_CH;
  assign acc_d = acc_q + TW'(cnt_q[idx_q] >= CNT_W'(THRESH)) + TW'($countones(rise_q[idx_q] & fall_q[idx_q]));
  always_ff @(posedge clock)
    if (clr) primed_q <= 1'b0;
    else if (smp) primed_q <= 1'b1;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] new_w;
    assign new_w = bus.sample_data[c*WIDTH +: WIDTH];
    always_ff @(posedge clock)
      if (clr) begin
        cnt_q[c] <= '0;
        rise_q[c] <= '0;
        fall_q[c] <= '0;
        last_q[c] <= '0;
      end else if (smp) begin
        last_q[c] <= new_w;
        if (primed_q && new_w != last_q[c]) begin
          cnt_q[c] <= cnt_q[c] + CNT_W'(cnt_q[c] != '1);
          rise_q[c] <= rise_q[c] | (new_w & ~last_q[c]);
          fall_q[c] <= fall_q[c] | (last_q[c] & ~new_w);
        end
      end
  end
  always_ff @(posedge clock)
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_count_q <= '0;
      rsp_rise_q <= '0;
      rsp_fall_q <= '0;
    end else begin
      rsp_valid_q <= rd_acc;
      if (rd_acc) begin
        rsp_err_q <= !in_rng;
        rsp_count_q <= in_rng ? cnt_q[bus.rd_addr] : '0;
        rsp_rise_q <= in_rng ? rise_q[bus.rd_addr] : '0;
        rsp_fall_q <= in_rng ? fall_q[bus.rd_addr] : '0;
      end
    end
  // a read request in IDLE takes precedence over a coincident sum_req
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      covered_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.clear_req) state_q <= IDLE;
      else
        case (state_q)
          IDLE:
            if (bus.sum_req && !bus.rd_valid) begin
              state_q <= SCAN;
              idx_q <= '0;
              acc_q <= '0;
            end
          SCAN: begin
            acc_q <= acc_d;
            idx_q <= idx_q + AW'(1);
            if (idx_q == AW'(NUM_CH - 1)) state_q <= DONE;
          end
          DONE: begin
            covered_q <= acc_q;
            done_q <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
    end
  assign bus.rd_ready = state_q == IDLE;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.rsp_count = rsp_count_q;
  assign bus.rsp_rise = rsp_rise_q;
  assign bus.rsp_fall = rsp_fall_q;
  assign bus.sum_busy = state_q != IDLE;
  assign bus.sum_done = done_q;
  assign bus.covered_total = covered_q;
  assign bus.bins_total = TW'(NUM_CH * (WIDTH + 1));
endmodule

// File: tb/tb_cov_toggle_monitor.sv
// tb_cov_toggle_monitor: directed table and sequence checks of cov_toggle_monitor
module tb_cov_toggle_monitor;
  logic clock = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clock = ~clock;
  cov_toggle_monitor_if #(.NUM_CH(4), .WIDTH(8), .CNT_W(4)) b();
  cov_toggle_monitor #(.NUM_CH(4), .WIDTH(8), .CNT_W(4), .THRESH(2)) dut (.clock(clock), .reset(reset), .bus(b));
  cov_toggle_monitor_if #(.NUM_CH(5), .WIDTH(8), .CNT_W(4)) b5();
  cov_toggle_monitor #(.NUM_CH(5), .WIDTH(8), .CNT_W(4), .THRESH(2)) dut5 (.clock(clock), .reset(reset), .bus(b5));
  typedef struct {
    logic en;
    logic [31:0] d;
    logic [1:0] ch;
    logic [3:0] c;
    logic [7:0] r;
    logic [7:0] f;
  } vec_t;
  vec_t tv [7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic samp(input logic en, input logic [31:0] d);
    b.cov_en = en;
    b.sample_valid = 1'b1;
    b.sample_data = d;
    tick();
    b.sample_valid = 1'b0;
  endtask
  task automatic rd(input string nm, input logic [1:0] a, input logic [3:0] ec, input logic [7:0] er, input logic [7:0] ef);
    chk({nm, " rd_ready"}, b.rd_ready, 1);
    b.rd_valid = 1'b1;
    b.rd_addr = a;
    tick();
    b.rd_valid = 1'b0;
    chk({nm, " rsp_valid"}, b.rsp_valid, 1);
    chk({nm, " rsp_err"}, b.rsp_err, 0);
    chk({nm, " rsp_count"}, b.rsp_count, ec);
    chk({nm, " rsp_rise"}, b.rsp_rise, er);
    chk({nm, " rsp_fall"}, b.rsp_fall, ef);
    tick();
    chk({nm, " rsp_valid pulse"}, b.rsp_valid, 0);
  endtask
  task automatic scan(input string nm, input logic [5:0] exp);
    b.sum_req = 1'b1;
    tick();
    b.sum_req = 1'b0;
    chk({nm, " busy"}, b.sum_busy, 1);
    chk({nm, " rd_ready low"}, b.rd_ready, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("%s done@%0d", nm, k), b.sum_done, k == 5);
      chk($sformatf("%s busy@%0d", nm, k), b.sum_busy, k < 5);
    end
    chk({nm, " covered_total"}, b.covered_total, exp);
    tick();
    chk({nm, " done pulse"}, b.sum_done, 0);
    chk({nm, " rd_ready back"}, b.rd_ready, 1);
  endtask
  initial begin
    tv[0] = '{1'b1, 32'h00000000, 2'd0, 4'd0, 8'h00, 8'h00};
    tv[1] = '{1'b1, 32'h00000001, 2'd0, 4'd1, 8'h01, 8'h00};
    tv[2] = '{1'b1, 32'h00000001, 2'd0, 4'd1, 8'h01, 8'h00};
    tv[3] = '{1'b1, 32'h00000003, 2'd0, 4'd2, 8'h03, 8'h00};
    tv[4] = '{1'b0, 32'h000000F0, 2'd0, 4'd2, 8'h03, 8'h00};
    tv[5] = '{1'b1, 32'h00000000, 2'd0, 4'd3, 8'h03, 8'h03};
    tv[6] = '{1'b1, 32'h00000000, 2'd0, 4'd3, 8'h03, 8'h03};
    b.cov_en = 1'b1;
    b.sample_valid = 1'b0;
    b.sample_data = '0;
    b.clear_req = 1'b0;
    b.rd_valid = 1'b0;
    b.rd_addr = '0;
    b.sum_req = 1'b0;
    b5.cov_en = 1'b0;
    b5.sample_valid = 1'b0;
    b5.sample_data = '0;
    b5.clear_req = 1'b0;
    b5.rd_valid = 1'b0;
    b5.rd_addr = '0;
    b5.sum_req = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset rsp_valid", b.rsp_valid, 0);
    chk("reset rsp_err", b.rsp_err, 0);
    chk("reset rsp_count", b.rsp_count, 0);
    chk("reset rsp_rise", b.rsp_rise, 0);
    chk("reset rsp_fall", b.rsp_fall, 0);
    chk("reset sum_busy", b.sum_busy, 0);
    chk("reset sum_done", b.sum_done, 0);
    chk("reset covered_total", b.covered_total, 0);
    chk("reset rd_ready", b.rd_ready, 1);
    chk("bins_total", b.bins_total, 36);
    for (int i = 0; i < 7; i++) begin
      samp(tv[i].en, tv[i].d);
      rd($sformatf("vec%0d", i), tv[i].ch, tv[i].c, tv[i].r, tv[i].f);
    end
    for (int i = 0; i < 20; i++) samp(1'b1, i % 2 == 0 ? 32'h0000FF00 : 32'h0);
    rd("sat ch1", 2'd1, 4'd15, 8'hFF, 8'hFF);
    scan("scan1", 6'd12);
    chk("bins_total after scan", b.bins_total, 36);
    for (int i = 0; i < 10; i++) samp(1'b0, i % 2 == 0 ? 32'h00FF0000 : 32'h0);
    samp(1'b1, 32'h00FF0000);
    rd("gate ch2", 2'd2, 4'd1, 8'hFF, 8'h00);
    scan("scan2", 6'd12);
    b.rd_valid = 1'b1;
    b.rd_addr = 2'd0;
    b.sum_req = 1'b1;
    tick();
    b.rd_valid = 1'b0;
    b.sum_req = 1'b0;
    chk("rd wins rsp_valid", b.rsp_valid, 1);
    chk("rd wins rsp_count", b.rsp_count, 3);
    chk("rd wins busy", b.sum_busy, 0);
    tick();
    b.sum_req = 1'b1;
    tick();
    b.sum_req = 1'b0;
    chk("abort rd_ready scan", b.rd_ready, 0);
    tick();
    tick();
    b.clear_req = 1'b1;
    tick();
    b.clear_req = 1'b0;
    chk("abort busy", b.sum_busy, 0);
    chk("abort rd_ready", b.rd_ready, 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("abort no done@%0d", k), b.sum_done, 0);
      tick();
    end
    chk("abort covered_total", b.covered_total, 12);
    rd("abort cleared ch1", 2'd1, 4'd0, 8'h00, 8'h00);
    samp(1'b1, 32'h11111111);
    b.clear_req = 1'b1;
    samp(1'b1, 32'h22222222);
    b.clear_req = 1'b0;
    for (int c = 0; c < 4; c++) rd($sformatf("clr ch%0d", c), 2'(c), 4'd0, 8'h00, 8'h00);
    samp(1'b1, 32'h33333333);
    rd("clr reprime", 2'd0, 4'd0, 8'h00, 8'h00);
    samp(1'b1, 32'h00000000);
    rd("clr recount", 2'd0, 4'd1, 8'h00, 8'h33);
    b.clear_req = 1'b1;
    tick();
    b.clear_req = 1'b0;
    chk("clr rsp_count hold", b.rsp_count, 1);
    chk("clr rsp_fall hold", b.rsp_fall, 8'h33);
    rd("clr after hold", 2'd0, 4'd0, 8'h00, 8'h00);
    b5.rd_valid = 1'b1;
    b5.rd_addr = 3'd5;
    tick();
    b5.rd_valid = 1'b0;
    chk("oob rsp_valid", b5.rsp_valid, 1);
    chk("oob rsp_err", b5.rsp_err, 1);
    chk("oob rsp_count", b5.rsp_count, 0);
    chk("oob rsp_rise", b5.rsp_rise, 0);
    chk("oob rsp_fall", b5.rsp_fall, 0);
    b5.rd_valid = 1'b1;
    b5.rd_addr = 3'd4;
    tick();
    b5.rd_valid = 1'b0;
    chk("inrange rsp_err", b5.rsp_err, 0);
    chk("bins_total 5ch", b5.bins_total, 45);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
